// File: rtl/pong_engine_if.sv
// ---------------------------------------------------------------------------
// pong_engine_if
//
// Bundles the player controls going into the pong game core and the game
// state coming out of it.
//
//   start                        level, only its rising edge is acted on
//   lpad_up/lpad_dn/rpad_up/rpad_dn  paddle controls, levels
//   ball_x, ball_y               ball top-left column / row
//   lpad_y, rpad_y               paddle top rows
//   lscore, rscore               scores
//   state                        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//   winner                       0 = left, 1 = right, meaningful in OVER
//   tick                         one-cycle game-tick strobe
//
// All signals are plain levels sampled on the rising clock edge; there is
// no valid/ready handshake on this bundle.
//
// Modports: master drives the controls (player side / bench),
//           slave is the game core.
// ---------------------------------------------------------------------------
interface pong_engine_if #(
    parameter int X_W  = 10,
    parameter int Y_W  = 9,
    parameter int SC_W = 3
) ();
    logic            start;
    logic            lpad_up;
    logic            lpad_dn;
    logic            rpad_up;
    logic            rpad_dn;
    logic [X_W-1:0]  ball_x;
    logic [Y_W-1:0]  ball_y;
    logic [Y_W-1:0]  lpad_y;
    logic [Y_W-1:0]  rpad_y;
    logic [SC_W-1:0] lscore;
    logic [SC_W-1:0] rscore;
    logic [2:0]      state;
    logic            winner;
    logic            tick;

    modport master (
        output start, lpad_up, lpad_dn, rpad_up, rpad_dn,
        input  ball_x, ball_y, lpad_y, rpad_y, lscore, rscore,
               state, winner, tick
    );

    modport slave (
        input  start, lpad_up, lpad_dn, rpad_up, rpad_dn,
        output ball_x, ball_y, lpad_y, rpad_y, lscore, rscore,
               state, winner, tick
    );
endinterface

// File: rtl/pong_engine.sv
// ---------------------------------------------------------------------------
// pong_engine
//
// Game-logic core of the pong design: ball and paddle motion, collisions,
// scoring and match flow. Positions are published for the renderer, which
// never feeds anything back.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   pong_engine_if.slave: player controls in, game state out
//
// Motion is evaluated once per game tick. The tick period starts at
// INIT_PERIOD each serve and shrinks by 1/8 on every paddle hit, floored at
// MIN_PERIOD. The vertical speed after a hit depends on which quarter of
// the paddle the ball centre struck.
// ---------------------------------------------------------------------------
module pong_engine #(
    parameter int COLS        = 640,
    parameter int ROWS        = 480,
    parameter int PAD_H       = 40,
    parameter int PAD_W       = 5,
    parameter int LPAD_X      = 5,
    parameter int RPAD_X      = 629,
    parameter int BALL_W      = 10,
    parameter int INIT_PERIOD = 500000,
    parameter int MIN_PERIOD  = 50000,
    parameter int WIN_SCORE   = 7
) (
    input  logic         clk,
    input  logic         rst,
    pong_engine_if.slave bus
);

    localparam int X_W    = $clog2(COLS);
    localparam int Y_W    = $clog2(ROWS);
    localparam int PER_W  = $clog2(INIT_PERIOD + 1);
    localparam int SC_W   = $clog2(WIN_SCORE + 1);
    localparam int CX     = (COLS - BALL_W) / 2;
    localparam int CY     = (ROWS - BALL_W) / 2;
    localparam int PY0    = (ROWS - PAD_H) / 2;
    localparam int ZONE_H = PAD_H / 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [X_W-1:0]    ball_x_q, ball_x_d;
    logic [Y_W-1:0]    ball_y_q, ball_y_d;
    logic [Y_W-1:0]    lpad_y_q, lpad_y_d;
    logic [Y_W-1:0]    rpad_y_q, rpad_y_d;
    logic              dx_neg_q, dx_neg_d;     // 1: ball moving left
    logic signed [2:0] dy_q, dy_d;             // rows per tick, -2..+2
    logic [PER_W-1:0]  period_q, period_d;
    logic [PER_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   lscore_q, lscore_d;
    logic [SC_W-1:0]   rscore_q, rscore_d;
    logic              winner_q, winner_d;
    logic              start_q, start_d;
    logic              left_scored_q, left_scored_d;  // scorer pending in POINT

    logic              tick;
    logic              start_rise;
    logic              hit_l, hit_r;
    logic              dx_neg_n;
    logic signed [2:0] dy_n;
    int                bx, by, lpy, rpy, ny, per_cut, new_score, other_score;

    // One paddle step: a single pressed button moves one row, clamped to the
    // playfield; both or neither pressed holds.
    function automatic logic [Y_W-1:0] pad_next(input logic [Y_W-1:0] y,
                                                 input logic up,
                                                 input logic dn);
        logic [Y_W-1:0] r;
        r = y;
        if (up && !dn && y != '0) begin
            r = Y_W'(int'(y) - 1);
        end else if (dn && !up && (int'(y) + PAD_H) != ROWS) begin
            r = Y_W'(int'(y) + 1);
        end
        return r;
    endfunction

    // Vertical speed after a hit, from the paddle quarter the ball centre is
    // in: top quarter sends the ball steeply up, bottom quarter steeply down.
    function automatic logic signed [2:0] zone_dy(input int ball_row, input int pad_row);
        int t;
        logic signed [2:0] r;
        t = ball_row + BALL_W / 2 - pad_row;
        if (t < 0) t = 0;
        if (t > PAD_H - 1) t = PAD_H - 1;
        case (t / ZONE_H)
            0:       r = 3'sb110;
            1:       r = 3'sb111;
            2:       r = 3'sb001;
            default: r = 3'sb010;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        lpad_y_d      = lpad_y_q;
        rpad_y_d      = rpad_y_q;
        dx_neg_d      = dx_neg_q;
        dy_d          = dy_q;
        period_d      = period_q;
        lscore_d      = lscore_q;
        rscore_d      = rscore_q;
        winner_d      = winner_q;
        left_scored_d = left_scored_q;
        start_d       = bus.start;
        start_rise    = bus.start & ~start_q;

        // Free-running tick counter. Period only changes on a tick (wrap) or
        // upward on reload, so the count never overshoots period-1.
        tick  = (int'(cnt_q) == int'(period_q) - 1);
        cnt_d = tick ? '0 : PER_W'(int'(cnt_q) + 1);

        bx          = int'(ball_x_q);
        by          = int'(ball_y_q);
        lpy         = int'(lpad_y_q);
        rpy         = int'(rpad_y_q);
        ny          = 0;
        per_cut     = 0;
        new_score   = 0;
        other_score = 0;
        dx_neg_n    = dx_neg_q;
        dy_n        = dy_q;

        hit_l = dx_neg_q && (bx == LPAD_X + PAD_W) &&
                (by + BALL_W > lpy) && (by < lpy + PAD_H);
        hit_r = !dx_neg_q && (bx + BALL_W == RPAD_X) &&
                (by + BALL_W > rpy) && (by < rpy + PAD_H);

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    lscore_d = '0;
                    rscore_d = '0;
                end
            end

            ST_SERVE: begin
                ball_x_d = X_W'(CX);
                ball_y_d = Y_W'(CY);
                period_d = PER_W'(INIT_PERIOD);
                if (tick) begin
                    lpad_y_d = pad_next(lpad_y_q, bus.lpad_up, bus.lpad_dn);
                    rpad_y_d = pad_next(rpad_y_q, bus.rpad_up, bus.rpad_dn);
                end
                if (start_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    lpad_y_d = pad_next(lpad_y_q, bus.lpad_up, bus.lpad_dn);
                    rpad_y_d = pad_next(rpad_y_q, bus.rpad_up, bus.rpad_dn);

                    if (hit_l || hit_r) begin
                        dx_neg_n = ~dx_neg_q;
                        dy_n     = zone_dy(by, hit_l ? lpy : rpy);
                        per_cut  = int'(period_q) - (int'(period_q) >> 3);
                        if (per_cut < MIN_PERIOD) per_cut = MIN_PERIOD;
                        period_d = PER_W'(per_cut);
                    end

                    if (dx_neg_q && bx == 0 && !hit_l) begin
                        state_d       = ST_POINT;
                        left_scored_d = 1'b0;
                    end else if (!dx_neg_q && bx == COLS - BALL_W && !hit_r) begin
                        state_d       = ST_POINT;
                        left_scored_d = 1'b1;
                    end else begin
                        dx_neg_d = dx_neg_n;
                        ball_x_d = dx_neg_n ? X_W'(bx - 1) : X_W'(bx + 1);
                        ny       = by + int'(dy_n);
                        dy_d     = dy_n;
                        if (ny < 0) begin
                            ball_y_d = '0;
                            dy_d     = -dy_n;
                        end else if (ny > ROWS - BALL_W) begin
                            ball_y_d = Y_W'(ROWS - BALL_W);
                            dy_d     = -dy_n;
                        end else begin
                            ball_y_d = Y_W'(ny);
                        end
                    end
                end
            end

            ST_POINT: begin
                if (left_scored_q) begin
                    new_score   = int'(lscore_q) + 1;
                    other_score = int'(rscore_q);
                end else begin
                    new_score   = int'(rscore_q) + 1;
                    other_score = int'(lscore_q);
                end
                if (new_score > WIN_SCORE) new_score = WIN_SCORE;
                if (left_scored_q) lscore_d = SC_W'(new_score);
                else               rscore_d = SC_W'(new_score);

                if (new_score >= WIN_SCORE) begin
                    state_d  = ST_OVER;
                    winner_d = ~left_scored_q;
                end else begin
                    state_d  = ST_SERVE;
                    ball_x_d = X_W'(CX);
                    ball_y_d = Y_W'(CY);
                    // Serve toward the player who just conceded.
                    dx_neg_d = ~left_scored_q;
                    dy_d     = (((new_score + other_score) & 1) == 1) ? 3'sb001 : 3'sb111;
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ball_x_q      <= X_W'(CX);
            ball_y_q      <= Y_W'(CY);
            lpad_y_q      <= Y_W'(PY0);
            rpad_y_q      <= Y_W'(PY0);
            dx_neg_q      <= 1'b0;
            dy_q          <= 3'sb001;
            period_q      <= PER_W'(INIT_PERIOD);
            cnt_q         <= '0;
            lscore_q      <= '0;
            rscore_q      <= '0;
            winner_q      <= 1'b0;
            start_q       <= 1'b0;
            left_scored_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            lpad_y_q      <= lpad_y_d;
            rpad_y_q      <= rpad_y_d;
            dx_neg_q      <= dx_neg_d;
            dy_q          <= dy_d;
            period_q      <= period_d;
            cnt_q         <= cnt_d;
            lscore_q      <= lscore_d;
            rscore_q      <= rscore_d;
            winner_q      <= winner_d;
            start_q       <= start_d;
            left_scored_q <= left_scored_d;
        end
    end

    assign bus.ball_x = ball_x_q;
    assign bus.ball_y = ball_y_q;
    assign bus.lpad_y = lpad_y_q;
    assign bus.rpad_y = rpad_y_q;
    assign bus.lscore = lscore_q;
    assign bus.rscore = rscore_q;
    assign bus.state  = state_q;
    assign bus.winner = winner_q;
    assign bus.tick   = tick;

endmodule
